// File: rtl/ysyx_22050710_lsu.sv
// Load/store unit: turns one byte/half/word/double access into 8-byte-aligned
// memory beats with lane masks, and extracts/extends load data for write-back.
// Optional macro YSYX_22050710_LSU_MISALIGN_SPLIT_EN: when defined, accesses that
// cross a doubleword boundary are split into two beats; when undefined they are
// rejected with o_resp_err=1 and never touch memory.
//
// state | meaning
// IDLE  | ready for a request
// BEAT0 | first (or only) beat offered to memory
// WAIT0 | waiting for the first beat's response
// BEAT1 | second beat of a crossing access (split build only)
// WAIT1 | waiting for the second beat's response (split build only)
// RESP  | result held for write-back
module ysyx_22050710_lsu #(
    parameter int ADDR_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [63:0]       i_wdata,
    input  logic [2:0]        i_MemOP,
    input  logic              i_WrEn,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [63:0]       o_mem_wdata,
    output logic [7:0]        o_mem_wmask,
    input  logic              i_mem_rvalid,
    input  logic [63:0]       i_mem_rdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [63:0]       o_rdata,
    output logic              o_resp_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        WAIT0 = 3'd2,
`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
        BEAT1 = 3'd3,
        WAIT1 = 3'd4,
`endif
        RESP  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] BEAT_STEP = ADDR_W'(8);

    state_t      state, state_nxt;
    logic [2:0]  off_q;
    logic [2:0]  op_q;

    logic [2:0]  off_in;
    logic [3:0]  sz;
    logic        crossing;
    logic        no_access;
    logic [7:0]  base_mask;
    logic [63:0] data_trunc;
    logic [7:0]  mask_lo;
    logic [63:0] data_lo;

    assign off_in    = i_addr[2:0];
    assign sz        = 4'd1 << i_MemOP[2:1];
    assign crossing  = ({1'b0, off_in} + sz) > 4'd8;
    assign no_access = (i_MemOP == 3'b111);

    // Right-aligned lane mask and store data trimmed to the access size
    always_comb begin
        base_mask  = 8'h00;
        data_trunc = 64'd0;
        case (i_MemOP[2:1])
            2'b00:   begin base_mask = 8'h01; data_trunc = {56'd0, i_wdata[7:0]};  end
            2'b01:   begin base_mask = 8'h03; data_trunc = {48'd0, i_wdata[15:0]}; end
            2'b10:   begin base_mask = 8'h0F; data_trunc = {32'd0, i_wdata[31:0]}; end
            default: begin base_mask = 8'hFF; data_trunc = i_wdata;                end
        endcase
    end

`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
    logic [15:0]  mask16;
    logic [127:0] data128;
    logic         cross_q;
    logic [7:0]   mask_hi_q;
    logic [63:0]  data_hi_q;
    logic [63:0]  rdata0_q;

    assign mask16  = i_WrEn ? ({8'd0, base_mask} << {1'b0, off_in}) : 16'd0;
    assign data128 = i_WrEn ? ({64'd0, data_trunc} << {off_in, 3'b000}) : 128'd0;
    assign mask_lo = mask16[7:0];
    assign data_lo = data128[63:0];
`else
    assign mask_lo = i_WrEn ? (base_mask << off_in) : 8'd0;
    assign data_lo = i_WrEn ? (data_trunc << {off_in, 3'b000}) : 64'd0;
`endif

    // Pick the addressed bytes out of the beat pair and extend them to 64 bits
    function automatic logic [63:0] extract(input logic [127:0] pair,
                                            input logic [2:0]   off,
                                            input logic [2:0]   op);
        logic [63:0] v;
        v = 64'(pair >> {off, 3'b000});
        case (op[2:1])
            2'b00:   return op[0] ? {56'd0, v[7:0]}  : {{56{v[7]}}, v[7:0]};
            2'b01:   return op[0] ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            2'b10:   return op[0] ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    assign o_req_ready  = (state == IDLE);
    assign o_resp_valid = (state == RESP);
`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
    assign o_mem_valid  = (state == BEAT0) || (state == BEAT1);
`else
    assign o_mem_valid  = (state == BEAT0);
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    if (no_access)     state_nxt = RESP;
`ifndef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
                    else if (crossing) state_nxt = RESP;
`endif
                    else               state_nxt = BEAT0;
                end
            end
            BEAT0: if (i_mem_ready) state_nxt = WAIT0;
`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
            WAIT0: if (i_mem_rvalid) state_nxt = cross_q ? BEAT1 : RESP;
            BEAT1: if (i_mem_ready)  state_nxt = WAIT1;
            WAIT1: if (i_mem_rvalid) state_nxt = RESP;
`else
            WAIT0: if (i_mem_rvalid) state_nxt = RESP;
`endif
            RESP:  if (i_resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latched request, registered beat payload and registered result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            off_q       <= 3'd0;
            op_q        <= 3'd0;
            o_mem_addr  <= '0;
            o_mem_wen   <= 1'b0;
            o_mem_wmask <= 8'd0;
            o_mem_wdata <= 64'd0;
            o_rdata     <= 64'd0;
            o_resp_err  <= 1'b0;
`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
            cross_q     <= 1'b0;
            mask_hi_q   <= 8'd0;
            data_hi_q   <= 64'd0;
            rdata0_q    <= 64'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        off_q       <= off_in;
                        op_q        <= i_MemOP;
                        o_mem_wen   <= i_WrEn;
                        o_mem_addr  <= {i_addr[ADDR_W-1:3], 3'b000};
                        o_mem_wmask <= mask_lo;
                        o_mem_wdata <= data_lo;
                        o_rdata     <= 64'd0;
`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
                        o_resp_err  <= 1'b0;
                        cross_q     <= crossing;
                        mask_hi_q   <= mask16[15:8];
                        data_hi_q   <= data128[127:64];
`else
                        o_resp_err  <= crossing && !no_access;
`endif
                    end
                end
                WAIT0: begin
                    if (i_mem_rvalid) begin
`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
                        rdata0_q <= i_mem_rdata;
                        if (cross_q) begin
                            o_mem_addr  <= o_mem_addr + BEAT_STEP;
                            o_mem_wmask <= mask_hi_q;
                            o_mem_wdata <= data_hi_q;
                        end else begin
                            o_rdata <= o_mem_wen ? 64'd0 : extract({64'd0, i_mem_rdata}, off_q, op_q);
                        end
`else
                        o_rdata <= o_mem_wen ? 64'd0 : extract({64'd0, i_mem_rdata}, off_q, op_q);
`endif
                    end
                end
`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
                WAIT1: begin
                    if (i_mem_rvalid)
                        o_rdata <= o_mem_wen ? 64'd0 : extract({i_mem_rdata, rdata0_q}, off_q, op_q);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// Self-checking bench for ysyx_22050710_lsu: a byte-level model predicts beats
// and results; a monitor compares beat payload and response on every cycle.
module tb_ysyx_22050710_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [63:0] i_addr;
    logic [63:0] i_wdata;
    logic [2:0]  i_MemOP;
    logic        i_WrEn;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [63:0] o_mem_addr;
    logic        o_mem_wen;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_rvalid;
    logic [63:0] i_mem_rdata;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [63:0] o_rdata;
    logic        o_resp_err;

    ysyx_22050710_lsu dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_MemOP      (i_MemOP),
        .i_WrEn       (i_WrEn),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wmask  (o_mem_wmask),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_rdata      (o_rdata),
        .o_resp_err   (o_resp_err)
    );

    always #5 i_clk = ~i_clk;

`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
    bit split_en = 1'b1;
`else
    bit split_en = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    int          exp_nbeats = 0;
    int          cur_beat   = 0;
    logic [63:0] exp_addr [2];
    logic [7:0]  exp_mask [2];
    logic [63:0] exp_data [2];
    logic        exp_wen;
    logic [63:0] exp_rdata;
    logic        exp_err;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Byte-by-byte model of one access
    task automatic model(input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] op,
                         input logic wr, input logic [63:0] r0, input logic [63:0] r1);
        int sz, off, p, b, lane;
        logic [63:0] v;
        logic [63:0] rd [2];
        sz = 1 << op[2:1];
        off = int'(addr[2:0]);
        rd[0] = r0;
        rd[1] = r1;
        exp_wen = wr;
        exp_rdata = 64'd0;
        exp_err = 1'b0;
        exp_mask[0] = 8'd0;  exp_mask[1] = 8'd0;
        exp_data[0] = 64'd0; exp_data[1] = 64'd0;
        exp_addr[0] = {addr[63:3], 3'b000};
        exp_addr[1] = exp_addr[0] + 64'd8;
        if (op == 3'b111) begin
            exp_nbeats = 0;
        end else if (off + sz > 8 && !split_en) begin
            exp_nbeats = 0;
            exp_err = 1'b1;
        end else begin
            exp_nbeats = (off + sz > 8) ? 2 : 1;
            v = 64'd0;
            for (int k = 0; k < sz; k++) begin
                p = off + k;
                b = p / 8;
                lane = p % 8;
                if (wr) begin
                    exp_mask[b][lane] = 1'b1;
                    exp_data[b][lane*8 +: 8] = wdata[k*8 +: 8];
                end else begin
                    v[k*8 +: 8] = rd[b][lane*8 +: 8];
                end
            end
            if (!op[0] && sz < 8 && v[sz*8-1])
                for (int k = sz * 8; k < 64; k++) v[k] = 1'b1;
            exp_rdata = wr ? 64'd0 : v;
        end
    endtask

    // Monitor: whatever the DUT presents must match the model
    always @(negedge i_clk) begin
        if (o_mem_valid) begin
            chk("beat_in_plan", 64'(cur_beat < exp_nbeats), 64'd1);
            if (cur_beat < exp_nbeats && cur_beat < 2) begin
                chk("beat_addr",  o_mem_addr,  exp_addr[cur_beat]);
                chk("beat_wmask", o_mem_wmask, exp_mask[cur_beat]);
                chk("beat_wdata", o_mem_wdata, exp_data[cur_beat]);
                chk("beat_wen",   o_mem_wen,   exp_wen);
            end
        end
        if (o_resp_valid) begin
            chk("resp_rdata", o_rdata,    exp_rdata);
            chk("resp_err",   o_resp_err, exp_err);
        end
        if (o_mem_valid || o_resp_valid)
            chk("req_ready_busy", o_req_ready, 1'b0);
    end

    // One complete access with memory and write-back acting as configured
    task automatic run(input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] op,
                       input logic wr, input logic [63:0] r0, input logic [63:0] r1,
                       input int rdy_lat, input int rsp_lat,
                       output logic [63:0] got_rdata, output logic [7:0] got_mask0,
                       output logic [63:0] got_data0, output logic got_err);
        model(addr, wdata, op, wr, r0, r1);
        cur_beat = 0;
        chk("req_ready_idle", o_req_ready, 1'b1);
        i_req_valid = 1'b1;
        i_addr = addr;
        i_wdata = wdata;
        i_MemOP = op;
        i_WrEn = wr;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        got_mask0 = o_mem_wmask;
        got_data0 = o_mem_wdata;
        for (int b = 0; b < exp_nbeats; b++) begin
            chk("mem_valid_lat", o_mem_valid, 1'b1);
            for (int k = 0; k < rdy_lat; k++) begin
                @(negedge i_clk);
                chk("mem_valid_hold", o_mem_valid, 1'b1);
            end
            i_mem_ready = 1'b1;
            @(negedge i_clk);
            i_mem_ready = 1'b0;
            chk("mem_valid_drop", o_mem_valid, 1'b0);
            cur_beat = b + 1;
            i_mem_rvalid = 1'b1;
            i_mem_rdata = (b == 0) ? r0 : r1;
            @(negedge i_clk);
            i_mem_rvalid = 1'b0;
        end
        chk("resp_valid_lat", o_resp_valid, 1'b1);
        got_rdata = o_rdata;
        got_err = o_resp_err;
        for (int k = 0; k < rsp_lat; k++) begin
            @(negedge i_clk);
            chk("resp_valid_hold", o_resp_valid, 1'b1);
            chk("resp_rdata_hold", o_rdata, got_rdata);
        end
        i_resp_ready = 1'b1;
        @(negedge i_clk);
        i_resp_ready = 1'b0;
        chk("resp_valid_drop", o_resp_valid, 1'b0);
        chk("req_ready_back", o_req_ready, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] g_rd;
        logic [7:0]  g_m;
        logic [63:0] g_d;
        logic        g_e;

        i_rst_n = 1'b0;
        i_req_valid = 1'b0;
        i_addr = 64'd0;
        i_wdata = 64'd0;
        i_MemOP = 3'b111;
        i_WrEn = 1'b0;
        i_mem_ready = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata = 64'd0;
        i_resp_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_req_ready",  o_req_ready,  1'b1);
        chk("rst_mem_valid",  o_mem_valid,  1'b0);
        chk("rst_resp_valid", o_resp_valid, 1'b0);
        chk("rst_mem_addr",   o_mem_addr,   64'd0);
        chk("rst_mem_wmask",  o_mem_wmask,  8'd0);
        chk("rst_mem_wdata",  o_mem_wdata,  64'd0);
        chk("rst_mem_wen",    o_mem_wen,    1'b0);
        chk("rst_rdata",      o_rdata,      64'd0);
        chk("rst_err",        o_resp_err,   1'b0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // lw, sign-extended upper word
        run(64'h8000_0004, 64'd0, 3'b100, 1'b0, 64'hAAAA_BBBB_8000_0001, 64'd0, 0, 0, g_rd, g_m, g_d, g_e);
        chk("lit_lw_rdata", g_rd, 64'hFFFF_FFFF_AAAA_BBBB);
        chk("lit_lw_mask", g_m, 8'h00);

        // sh at offset 3
        run(64'h8000_0003, 64'h1234_5678_9ABC_DEF0, 3'b010, 1'b1, 64'd0, 64'd0, 0, 0, g_rd, g_m, g_d, g_e);
        chk("lit_sh_mask", g_m, 8'h18);
        chk("lit_sh_data", g_d, 64'h0000_00DE_F000_0000);
        chk("lit_sh_rdata", g_rd, 64'd0);

        // lbu / lb on the top byte
        run(64'h8000_0007, 64'd0, 3'b001, 1'b0, 64'h8100_0000_0000_0000, 64'd0, 0, 0, g_rd, g_m, g_d, g_e);
        chk("lit_lbu", g_rd, 64'h0000_0000_0000_0081);
        run(64'h8000_0007, 64'd0, 3'b000, 1'b0, 64'h8100_0000_0000_0000, 64'd0, 0, 0, g_rd, g_m, g_d, g_e);
        chk("lit_lb", g_rd, 64'hFFFF_FFFF_FFFF_FF81);

        // ld crossing a doubleword boundary
        run(64'h8000_0005, 64'd0, 3'b110, 1'b0, 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00,
            0, 0, g_rd, g_m, g_d, g_e);
`ifdef YSYX_22050710_LSU_MISALIGN_SPLIT_EN
        chk("lit_ld_cross", g_rd, 64'hCCDD_EEFF_0011_2233);
        chk("lit_ld_cross_err", g_e, 1'b0);
`else
        chk("lit_ld_cross", g_rd, 64'd0);
        chk("lit_ld_cross_err", g_e, 1'b1);
`endif

        // lhu / lh at offset 6 (ends exactly at the boundary)
        run(64'h8000_0006, 64'd0, 3'b011, 1'b0, 64'hBEEF_0000_0000_0000, 64'd0, 0, 0, g_rd, g_m, g_d, g_e);
        chk("lit_lhu", g_rd, 64'h0000_0000_0000_BEEF);
        run(64'h8000_0006, 64'd0, 3'b010, 1'b0, 64'hBEEF_0000_0000_0000, 64'd0, 0, 0, g_rd, g_m, g_d, g_e);
        chk("lit_lh", g_rd, 64'hFFFF_FFFF_FFFF_BEEF);

        // backpressure on both sides
        run(64'h8000_0010, 64'd0, 3'b101, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 3, 2, g_rd, g_m, g_d, g_e);
        chk("lit_lwu_bp", g_rd, 64'h0000_0000_89AB_CDEF);

        // aligned sd with write backpressure
        run(64'h8000_0100, 64'hDEAD_BEEF_0BAD_F00D, 3'b110, 1'b1, 64'd0, 64'd0, 2, 1, g_rd, g_m, g_d, g_e);
        chk("lit_sd_mask", g_m, 8'hFF);
        chk("lit_sd_data", g_d, 64'hDEAD_BEEF_0BAD_F00D);

        // no-access op
        run(64'h8000_0203, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 1'b1, 64'd0, 64'd0, 0, 1, g_rd, g_m, g_d, g_e);
        chk("lit_noop_rdata", g_rd, 64'd0);
        chk("lit_noop_err", g_e, 1'b0);

        // crossing sw and a crossing lh that wraps the address space
        run(64'h8000_000E, 64'h0000_0000_CAFE_F00D, 3'b100, 1'b1, 64'd0, 64'd0, 1, 0, g_rd, g_m, g_d, g_e);
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'b010, 1'b0, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD,
            0, 0, g_rd, g_m, g_d, g_e);

        // reset while waiting for the read response
        model(64'h8000_0020, 64'd0, 3'b110, 1'b0, 64'h5555_5555_5555_5555, 64'd0);
        cur_beat = 0;
        i_req_valid = 1'b1;
        i_addr = 64'h8000_0020;
        i_MemOP = 3'b110;
        i_WrEn = 1'b0;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("rst_pre_beat", o_mem_valid, 1'b1);
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        chk("rst_in_wait", o_mem_valid, 1'b0);
        exp_nbeats = 0;
        #2 i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_mem_valid",  o_mem_valid,  1'b0);
        chk("rst_mid_resp_valid", o_resp_valid, 1'b0);
        chk("rst_mid_req_ready",  o_req_ready,  1'b1);
        i_rst_n = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata = 64'h5555_5555_5555_5555;
        @(negedge i_clk);
        i_mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("late_rvalid_resp", o_resp_valid, 1'b0);
            chk("late_rvalid_mem",  o_mem_valid,  1'b0);
            chk("late_rvalid_idle", o_req_ready,  1'b1);
        end

        // normal operation after reset
        run(64'h8000_0022, 64'd0, 3'b000, 1'b0, 64'h0000_0000_007F_0000, 64'd0, 0, 0, g_rd, g_m, g_d, g_e);
        chk("lit_lb_pos", g_rd, 64'h0000_0000_0000_007F);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
